// File: rtl/frame_feature_extractor.sv
// frame_feature_extractor
// Streams one frame of NUM_SEG segments of 2^SEG_LEN_LOG2 signed samples and
// produces per-segment mean and variance. The results are published as one
// double-buffered vector with a single-cycle valid pulse.
module frame_feature_extractor #(
  parameter int SAMPLE_W     = 12,
  parameter int SEG_LEN_LOG2 = 8,
  parameter int NUM_SEG      = 13,
  parameter int FEAT_W       = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       busy,
  output logic        [FEAT_W-1:0]   features [2*NUM_SEG],
  output logic                       features_valid
);

  localparam int SUM_W    = SAMPLE_W + SEG_LEN_LOG2;
  localparam int SQ_W     = 2 * SAMPLE_W + SEG_LEN_LOG2;
  localparam int SEG_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int MSQ_W    = 2 * SUM_W;
  localparam int VAR_W    = ((MSQ_W > SQ_W) ? MSQ_W : SQ_W) + 2;
  localparam int MEAN_MAX = 2 ** (FEAT_W - 1) - 1;
  localparam int MEAN_MIN = -(2 ** (FEAT_W - 1));
  localparam int VAR_MAX  = 2 ** FEAT_W - 1;

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, DONE} state_t;

  state_t                      r_state;
  state_t                      w_nextState;

  logic signed [SUM_W-1:0]     r_sum;
  logic        [SQ_W-1:0]      r_sumSq;
  logic [SEG_LEN_LOG2-1:0]     r_count;
  logic        [SEG_W-1:0]     r_seg;
  logic        [FEAT_W-1:0]    r_bank     [2*NUM_SEG];
  logic        [FEAT_W-1:0]    r_features [2*NUM_SEG];
  logic                        r_featuresValid;

  logic                        w_accept;
  logic                        w_lastSample;
  logic                        w_lastSeg;
  logic signed [2*SAMPLE_W-1:0] w_sampleSq;
  logic signed [SUM_W-1:0]     w_mean;
  logic signed [MSQ_W-1:0]     w_meanSq;
  logic        [SQ_W-1:0]      w_sqAvg;
  logic signed [VAR_W-1:0]     w_varRaw;
  logic        [FEAT_W-1:0]    w_meanSat;
  logic        [FEAT_W-1:0]    w_varSat;

  // Acceptance is decoded from the registered state so ready never loops back into itself.
  assign w_accept     = sample_valid && (r_state == ACCUM);
  assign w_lastSample = w_accept && (r_count == {SEG_LEN_LOG2{1'b1}});
  assign w_lastSeg    = (r_seg == SEG_W'(NUM_SEG - 1));
  assign w_sampleSq   = sample_in * sample_in;

  // Segment statistics: floor mean, then E[x^2] - mean^2 at a width that cannot wrap.
  always_comb begin
    w_mean   = r_sum >>> SEG_LEN_LOG2;
    w_meanSq = w_mean * w_mean;
    w_sqAvg  = r_sumSq >> SEG_LEN_LOG2;
    w_varRaw = $signed(VAR_W'(w_sqAvg)) - VAR_W'(w_meanSq);
  end

  // Clamp mean into signed FEAT_W range and variance into [0, 2^FEAT_W-1].
  always_comb begin
    w_meanSat = w_mean[FEAT_W-1:0];
    if (w_mean > $signed(SUM_W'(MEAN_MAX))) begin
      w_meanSat = {1'b0, {(FEAT_W-1){1'b1}}};
    end else if (w_mean < $signed(SUM_W'(MEAN_MIN))) begin
      w_meanSat = {1'b1, {(FEAT_W-1){1'b0}}};
    end
    w_varSat = w_varRaw[FEAT_W-1:0];
    if (w_varRaw < 0) begin
      w_varSat = '0;
    end else if (w_varRaw > $signed(VAR_W'(VAR_MAX))) begin
      w_varSat = '1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the handshake/status outputs.
  always_comb begin
    w_nextState  = r_state;
    sample_ready = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_nextState = ACCUM;
      end
      ACCUM: begin
        sample_ready = 1'b1;
        if (w_lastSample) w_nextState = CALC;
      end
      CALC: begin
        w_nextState = w_lastSeg ? DONE : ACCUM;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Accumulators, working bank and the published feature bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum           <= '0;
      r_sumSq         <= '0;
      r_count         <= '0;
      r_seg           <= '0;
      r_featuresValid <= 1'b0;
      for (int i = 0; i < 2 * NUM_SEG; i++) begin
        r_bank[i]     <= '0;
        r_features[i] <= '0;
      end
    end else begin
      r_featuresValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sum   <= '0;
            r_sumSq <= '0;
            r_count <= '0;
            r_seg   <= '0;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_sum   <= r_sum + SUM_W'(sample_in);
            r_sumSq <= r_sumSq + SQ_W'($unsigned(w_sampleSq));
            r_count <= r_count + SEG_LEN_LOG2'(1);
          end
        end
        CALC: begin
          r_bank[int'(r_seg)]           <= w_meanSat;
          r_bank[NUM_SEG + int'(r_seg)] <= w_varSat;
          r_sum   <= '0;
          r_sumSq <= '0;
          r_count <= '0;
          if (!w_lastSeg) r_seg <= r_seg + SEG_W'(1);
        end
        DONE: begin
          for (int i = 0; i < 2 * NUM_SEG; i++) begin
            r_features[i] <= r_bank[i];
          end
          r_featuresValid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign features       = r_features;
  assign features_valid = r_featuresValid;

endmodule

// File: tb/tb_frame_feature_extractor.sv
// tb_frame_feature_extractor
// Randomised frames checked against a behavioural statistics model; a single
// compare process checks the published features and valid pulse every cycle.
module tb_frame_feature_extractor;

  localparam int SAMPLE_W = 12;
  localparam int SEG_LEN  = 256;
  localparam int NUM_SEG  = 13;
  localparam int FEAT_W   = 12;
  localparam int NFEAT    = 2 * NUM_SEG;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;
  logic                       busy;
  logic        [FEAT_W-1:0]   features [NFEAT];
  logic                       features_valid;

  int          checksTotal  = 0;
  int          checksPassed = 0;
  logic [FEAT_W-1:0] expFeat [NFEAT];
  logic [FEAT_W-1:0] newFeat [NFEAT];
  logic        expValid  = 1'b0;
  bit          compareOn = 1'b0;
  int          sampleQ[$];
  int          kSeg = 4;

  frame_feature_extractor #(
    .SAMPLE_W(SAMPLE_W), .SEG_LEN_LOG2(8), .NUM_SEG(NUM_SEG), .FEAT_W(FEAT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
    .features(features), .features_valid(features_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Published outputs must match the model every cycle: old vector held, new one after DONE.
  always @(negedge clk) begin : compareProc
    int bad;
    if (compareOn) begin
      checkOutput("features_valid", {31'd0, features_valid}, {31'd0, expValid});
      bad = -1;
      for (int i = 0; i < NFEAT; i++) begin
        if (bad < 0 && features[i] !== expFeat[i]) bad = i;
      end
      checksTotal++;
      if (bad < 0) checksPassed++;
      else $display("[TB] FAIL features[%0d]: got 0x%0h expected 0x%0h", bad, features[bad], expFeat[bad]);
    end
  end

  // Behavioural model: floor mean and clamped variance per segment from accepted samples.
  task automatic computeModel();
    longint s, q, v, mean, varr;
    checkOutput("accepted_count", sampleQ.size(), NUM_SEG * SEG_LEN);
    for (int seg = 0; seg < NUM_SEG; seg++) begin
      s = 0;
      q = 0;
      for (int j = 0; j < SEG_LEN; j++) begin
        v = longint'(sampleQ[seg * SEG_LEN + j]);
        s += v;
        q += v * v;
      end
      mean = s / SEG_LEN;
      if (s < 0 && (s % SEG_LEN) != 0) mean = mean - 1;
      varr = q / SEG_LEN - mean * mean;
      if (varr < 0) varr = 0;
      if (varr > 4095) varr = 4095;
      if (mean > 2047) mean = 2047;
      if (mean < -2048) mean = -2048;
      newFeat[seg]           = mean[FEAT_W-1:0];
      newFeat[NUM_SEG + seg] = varr[FEAT_W-1:0];
    end
  endtask

  function automatic logic signed [SAMPLE_W-1:0] genSample(input int mode, input int seg, input int idx);
    logic signed [SAMPLE_W-1:0] r;
    r = SAMPLE_W'($urandom);
    case (mode)
      0: r = 12'sd100;
      1: r = (seg == kSeg) ? ((idx % 2 == 0) ? 12'sd40 : -12'sd40) : -12'sd5;
      2: r = (seg == 1) ? ((idx == SEG_LEN - 1) ? -12'sd1 : 12'sd0)
                        : ((idx % 2 == 0) ? 12'sd2047 : -12'sd2047);
      default: ;
    endcase
    return r;
  endfunction

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      expValid = 1'b0;
    end
  endtask

  // Drive one frame (called #1 after an edge, DUT in IDLE); optionally abort with rst.
  task automatic applyStimulus(input int mode, input int validPct, input bit spamStart, input int abortSeg);
    bit v;
    int acc;
    sampleQ.delete();
    start        = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", {31'd0, sample_ready}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    expValid = 1'b0;
    for (int seg = 0; seg < NUM_SEG; seg++) begin
      acc = 0;
      while (acc < SEG_LEN) begin
        if (seg == abortSeg && acc == SEG_LEN / 2) begin
          rst          = 1'b1;
          sample_valid = 1'b1;
          @(posedge clk);
          #1;
          rst          = 1'b0;
          sample_valid = 1'b0;
          for (int i = 0; i < NFEAT; i++) expFeat[i] = '0;
          expValid = 1'b0;
          @(negedge clk);
          checkOutput("abort_ready", {31'd0, sample_ready}, 32'd0);
          checkOutput("abort_busy", {31'd0, busy}, 32'd0);
          @(posedge clk);
          #1;
          return;
        end
        v            = ($urandom_range(99) < validPct);
        sample_valid = v;
        sample_in    = genSample(mode, seg, acc);
        start        = spamStart ? 1'($urandom_range(1)) : 1'b0;
        @(negedge clk);
        checkOutput("accum_ready", {31'd0, sample_ready}, 32'd1);
        checkOutput("accum_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        if (v) begin
          sampleQ.push_back(int'(sample_in));
          acc++;
        end
      end
      sample_valid = 1'b1;
      sample_in    = SAMPLE_W'($urandom);
      start        = spamStart;
      @(negedge clk);
      checkOutput("bubble_ready", {31'd0, sample_ready}, 32'd0);
      checkOutput("bubble_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    computeModel();
    sample_valid = 1'b1;
    sample_in    = SAMPLE_W'($urandom);
    start        = spamStart;
    @(negedge clk);
    checkOutput("done_ready", {31'd0, sample_ready}, 32'd0);
    checkOutput("done_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    start        = 1'b0;
    expFeat      = newFeat;
    expValid     = 1'b1;
  endtask

  // Literal pins on both the model's value and the published DUT value.
  task automatic pinCheck(input string name, input int idx, input logic [FEAT_W-1:0] lit);
    checkOutput({"model_", name}, {20'd0, expFeat[idx]}, {20'd0, lit});
    checkOutput({"dut_", name}, {20'd0, features[idx]}, {20'd0, lit});
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    for (int i = 0; i < NFEAT; i++) expFeat[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    compareOn = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", {31'd0, sample_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    idleCycles(2);

    $display("[TB] constant 100 frame");
    applyStimulus(0, 100, 1'b0, -1);
    pinCheck("const_mean0", 0, 12'd100);
    pinCheck("const_mean12", 12, 12'd100);
    pinCheck("const_var0", 13, 12'd0);
    pinCheck("const_var12", 25, 12'd0);

    $display("[TB] alternating +-40 segment, back-to-back start");
    applyStimulus(1, 100, 1'b0, -1);
    pinCheck("alt_mean_k", kSeg, 12'd0);
    pinCheck("alt_var_k", NUM_SEG + kSeg, 12'd1600);
    pinCheck("alt_mean_other", 0, 12'hFFB);
    pinCheck("alt_var_other", NUM_SEG, 12'd0);
    idleCycles(3);

    $display("[TB] saturation and clamp frame");
    applyStimulus(2, 100, 1'b0, -1);
    pinCheck("sat_mean", 0, 12'd0);
    pinCheck("sat_var", NUM_SEG, 12'd4095);
    pinCheck("neg_mean", 1, 12'hFFF);
    pinCheck("neg_var", NUM_SEG + 1, 12'd0);
    idleCycles(2);

    $display("[TB] random gaps with start spam");
    applyStimulus(3, 70, 1'b1, -1);
    idleCycles(2);

    $display("[TB] abort in segment 6");
    applyStimulus(3, 100, 1'b0, 6);
    idleCycles(2);

    $display("[TB] fresh frame after abort");
    applyStimulus(3, 80, 1'b0, -1);
    idleCycles(3);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
